// File: rtl/turn_signal_input_cond_if.sv
// Signal bundle between the turn-switch conditioner and its neighbours:
// raw switch inputs in, slow clock / tick / conditioned requests out.
interface turn_signal_input_cond_if;
  logic l_raw;
  logic r_raw;
  logic haz_raw;
  logic slow_clk;
  logic tick;
  logic L;
  logic R;
  logic haz_active;

  modport master (
    output l_raw, r_raw, haz_raw,
    input  slow_clk, tick, L, R, haz_active
  );

  modport slave (
    input  l_raw, r_raw, haz_raw,
    output slow_clk, tick, L, R, haz_active
  );
endinterface

// File: rtl/turn_signal_input_cond.sv
// Turn-switch front end: 2-flop sync + debounce, slow-clock divider, and L/R
// sampled on slow_clk falls. Optional hazard latch under macro HAZARD_LATCH_EN.
module turn_signal_input_cond #(
  parameter int unsigned DIV_COUNT = 12_500_000,
  parameter int unsigned DB_CYCLES = 250_000
) (
  input  logic                      clk,
  input  logic                      reset,
  turn_signal_input_cond_if.slave   bus
);

  localparam int unsigned CW  = $clog2(DIV_COUNT);
  localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
`ifdef HAZARD_LATCH_EN
  localparam int unsigned NCH = 3;
`else
  localparam int unsigned NCH = 2;
`endif

  // Channel 0 = left, 1 = right, 2 = hazard (when built in)
  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1_q, sync1_d;
  logic [NCH-1:0] sync2_q, sync2_d;
  logic [NCH-1:0] db_q, db_d;
  logic [DBW-1:0] dbc_q [NCH];
  logic [DBW-1:0] dbc_d [NCH];

  logic [CW-1:0]  cnt_q, cnt_d;
  logic           slow_q, slow_d;
  logic           tick_q, tick_d;
  logic           l_q, l_d;
  logic           r_q, r_d;
  logic           wrap;
  logic           haz_mode;

`ifdef HAZARD_LATCH_EN
  assign raw = {bus.haz_raw, bus.r_raw, bus.l_raw};
`else
  assign raw = {bus.r_raw, bus.l_raw};
  logic unused_haz_raw;
  assign unused_haz_raw = bus.haz_raw;
`endif

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      dbc_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (dbc_q[i] == DBW'(DB_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + DBW'(1);
        end
      end
    end
  end

  // L/R are refreshed only as slow_clk falls, so they are stable around each rise
  always_comb begin
    wrap   = (cnt_q == CW'(DIV_COUNT - 1));
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    slow_d = slow_q ^ wrap;
    tick_d = wrap && !slow_q;
    l_d    = l_q;
    r_d    = r_q;
    if (wrap && slow_q) begin
      l_d = db_q[0] | haz_mode;
      r_d = db_q[1] | haz_mode;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      dbc_q   <= '{default: '0};
      cnt_q   <= '0;
      slow_q  <= 1'b0;
      tick_q  <= 1'b0;
      l_q     <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      dbc_q   <= dbc_d;
      cnt_q   <= cnt_d;
      slow_q  <= slow_d;
      tick_q  <= tick_d;
      l_q     <= l_d;
      r_q     <= r_d;
    end
  end

`ifdef HAZARD_LATCH_EN
  logic haz_mode_q, haz_mode_d;

  // Toggle on each accepted 0->1 of the debounced hazard button
  always_comb begin
    haz_mode_d = haz_mode_q ^ (db_d[2] & ~db_q[2]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      haz_mode_q <= 1'b0;
    end else begin
      haz_mode_q <= haz_mode_d;
    end
  end

  assign haz_mode = haz_mode_q;
`else
  assign haz_mode = 1'b0;
`endif

  assign bus.slow_clk   = slow_q;
  assign bus.tick       = tick_q;
  assign bus.L          = l_q;
  assign bus.R          = r_q;
  assign bus.haz_active = haz_mode;

endmodule

// File: tb/tb_turn_signal_input_cond.sv
// Directed bench for turn_signal_input_cond with DIV_COUNT=4, DB_CYCLES=3;
// expected L/R/hazard values are queued with the stimulus and checked at each slow_clk fall.
module tb_turn_signal_input_cond;

  localparam int unsigned DIV = 4;
  localparam int unsigned DB  = 3;
`ifdef HAZARD_LATCH_EN
  localparam logic HAZ_EN = 1'b1;
`else
  localparam logic HAZ_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  turn_signal_input_cond_if bus ();

  turn_signal_input_cond #(.DIV_COUNT(DIV), .DB_CYCLES(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    logic  l;
    logic  r;
    logic  haz;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic l, input logic r, input logic h);
    exp_t e;
    e.tag = tag;
    e.l   = l;
    e.r   = r;
    e.haz = h;
    sb.push_back(e);
  endtask

  task automatic expect_fall();
    logic prev;
    bit   seen;
    exp_t e;
    prev = bus.slow_clk;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && bus.slow_clk === 1'b0) seen = 1'b1;
      prev = bus.slow_clk;
    end
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=entry");
    end else begin
      e = sb.pop_front();
      if (!seen) begin
        checks++;
        failures++;
        $error("FAIL %s_timeout observed=no_fall expected=fall", e.tag);
      end else begin
        check({e.tag, "_L"},   bus.L,          e.l);
        check({e.tag, "_R"},   bus.R,          e.r);
        check({e.tag, "_haz"}, bus.haz_active, e.haz);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_slow"}, bus.slow_clk,   1'b0);
    check({tag, "_tick"}, bus.tick,       1'b0);
    check({tag, "_L"},    bus.L,          1'b0);
    check({tag, "_R"},    bus.R,          1'b0);
    check({tag, "_haz"},  bus.haz_active, 1'b0);
  endtask

  // Returns at the negedge where reset drops; the next posedge is edge 1
  task automatic do_reset(input logic l, input logic r, input logic h);
    @(negedge clk);
    reset       = 1'b1;
    bus.l_raw   = l;
    bus.r_raw   = r;
    bus.haz_raw = h;
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b0;
  endtask

  initial begin
    bus.l_raw   = 1'b0;
    bus.r_raw   = 1'b0;
    bus.haz_raw = 1'b0;

    // Divider / tick timing with quiet inputs
    do_reset(1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 24; e++) begin
      @(negedge clk);
      check($sformatf("div_slow_e%0d", e), bus.slow_clk, logic'(((e / 4) % 2) == 1));
      check($sformatf("div_tick_e%0d", e), bus.tick,     logic'((e % 8) == 4));
      check($sformatf("div_L_e%0d", e),    bus.L,        1'b0);
    end

    // Left held: L rises at first fall and holds across the following rise
    do_reset(1'b1, 1'b0, 1'b0);
    push("lhold1", 1'b1, 1'b0, 1'b0);
    expect_fall();
    for (int e = 9; e <= 15; e++) begin
      @(negedge clk);
      check($sformatf("lhold_L_e%0d", e), bus.L, 1'b1);
      check($sformatf("lhold_R_e%0d", e), bus.R, 1'b0);
    end
    push("lhold2", 1'b1, 1'b0, 1'b0);
    expect_fall();

    // Two-cycle bounce never accepted
    do_reset(1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus.l_raw = 1'b0;
    for (int i = 0; i < 3; i++) push($sformatf("bounce%0d", i), 1'b0, 1'b0, 1'b0);
    repeat (3) expect_fall();

    // Left and right together
    do_reset(1'b1, 1'b1, 1'b0);
    push("lr", 1'b1, 1'b1, 1'b0);
    expect_fall();

    // Hazard press on, hold, press off
    do_reset(1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    bus.haz_raw = 1'b0;
    push("haz_on", HAZ_EN, HAZ_EN, HAZ_EN);
    expect_fall();
    push("haz_hold", HAZ_EN, HAZ_EN, HAZ_EN);
    expect_fall();
    bus.haz_raw = 1'b1;
    repeat (5) @(negedge clk);
    bus.haz_raw = 1'b0;
    push("haz_off", 1'b0, 1'b0, 1'b0);
    expect_fall();

    // Mid-period reset with L=1: immediate clear, divider restarts
    do_reset(1'b1, 1'b0, 1'b0);
    push("pre_rst", 1'b1, 1'b0, 1'b0);
    expect_fall();
    repeat (5) @(negedge clk);
    check("mid_slow_high", bus.slow_clk, 1'b1);
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      check($sformatf("restart_slow_e%0d", e), bus.slow_clk, logic'(e >= 4));
      check($sformatf("restart_tick_e%0d", e), bus.tick,     logic'(e == 4));
      check($sformatf("restart_L_e%0d", e),    bus.L,        1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
